// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter feeding the register file's single write port
// through one staging register. Optional read bypass of the staged write: WB_BYPASS_EN.
module regfile_wb_arbiter #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int NREQ  = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [NREQ*$clog2(DEPTH)-1:0] req_addr,
   input  logic [NREQ*WIDTH-1:0]       req_data,
   output logic [NREQ-1:0]             req_ready,
   input  logic                        wb_stall,
   output logic                        we0,
   output logic [$clog2(DEPTH)-1:0]    wr_addr0,
   output logic [WIDTH-1:0]            wr_din0,
   input  logic [$clog2(DEPTH)-1:0]    rd_addr0,
   input  logic [$clog2(DEPTH)-1:0]    rd_addr1,
   input  logic [WIDTH-1:0]            rf_dout0,
   input  logic [WIDTH-1:0]            rf_dout1,
   output logic [WIDTH-1:0]            rd_dout0,
   output logic [WIDTH-1:0]            rd_dout1,
   output logic                        busy,
   output logic [31:0]                 commit_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic             r_stg_valid;
   logic [AW-1:0]    r_stg_addr;
   logic [WIDTH-1:0] r_stg_data;
   logic [PW-1:0]    r_rr_ptr;
   logic [31:0]      r_commit_cnt;

   logic             w_found;
   logic [PW-1:0]    w_sel;
   logic             w_accept;
   logic             w_we;
   logic [AW-1:0]    w_addr;
   logic [WIDTH-1:0] w_data;
   logic [PW-1:0]    w_ptr_nxt;

   // Scan from the round-robin pointer, wrapping modulo NREQ.
   always_comb begin
      logic [PW:0] w_sum;
      w_found = 1'b0;
      w_sel   = '0;
      w_sum   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
         if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
         if (!w_found && req_valid[w_sum[PW-1:0]]) begin
            w_found = 1'b1;
            w_sel   = w_sum[PW-1:0];
         end
      end
   end

   // Reset gates the handshake and write port so nothing slips through the reset cycle.
   assign w_accept  = w_found & ~wb_stall & rst;
   assign req_ready = w_accept ? (NREQ'(1) << w_sel) : '0;
   assign w_addr    = req_addr[w_sel*AW +: AW];
   assign w_data    = req_data[w_sel*WIDTH +: WIDTH];
   assign w_ptr_nxt = (w_sel == PW'(NREQ-1)) ? '0 : w_sel + 1'b1;
   assign w_we      = r_stg_valid & ~wb_stall & rst;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stg_valid  <= 1'b0;
         r_stg_addr   <= '0;
         r_stg_data   <= '0;
         r_rr_ptr     <= '0;
         r_commit_cnt <= '0;
      end else begin
         if (w_we) r_commit_cnt <= r_commit_cnt + 32'd1;
         if (!wb_stall) begin
            r_stg_valid <= 1'b0;
            if (w_accept) begin
               r_rr_ptr <= w_ptr_nxt;
               // Writes to x0 are consumed but never staged.
               if (w_addr != '0) begin
                  r_stg_valid <= 1'b1;
                  r_stg_addr  <= w_addr;
                  r_stg_data  <= w_data;
               end
            end
         end
      end
   end

   assign we0        = w_we;
   assign wr_addr0   = rst ? r_stg_addr : '0;
   assign wr_din0    = rst ? r_stg_data : '0;
   assign busy       = r_stg_valid & rst;
   assign commit_cnt = r_commit_cnt;

`ifdef WB_BYPASS_EN
   logic w_hit0, w_hit1;
   assign w_hit0   = r_stg_valid && (r_stg_addr != '0) && (r_stg_addr == rd_addr0);
   assign w_hit1   = r_stg_valid && (r_stg_addr != '0) && (r_stg_addr == rd_addr1);
   assign rd_dout0 = w_hit0 ? r_stg_data : rf_dout0;
   assign rd_dout1 = w_hit1 ? r_stg_data : rf_dout1;
`else
   logic w_unused_rd;
   assign w_unused_rd = ^{rd_addr0, rd_addr1};
   assign rd_dout0    = rf_dout0;
   assign rd_dout1    = rf_dout1;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic checked
// against a scoreboard model of grant order, staging and commit count.
module tb_regfile_wb_arbiter;

   localparam int W  = 32;
   localparam int D  = 32;
   localparam int N  = 3;
   localparam int AW = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*W-1:0]  req_data;
   logic [N-1:0]    req_ready;
   logic            wb_stall;
   logic            we0;
   logic [AW-1:0]   wr_addr0;
   logic [W-1:0]    wr_din0;
   logic [AW-1:0]   rd_addr0, rd_addr1;
   logic [W-1:0]    rf_dout0, rf_dout1, rd_dout0, rd_dout1;
   logic            busy;
   logic [31:0]     commit_cnt;

   regfile_wb_arbiter #(.WIDTH(W), .DEPTH(D), .NREQ(N)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
      .we0(we0), .wr_addr0(wr_addr0), .wr_din0(wr_din0),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rf_dout0(rf_dout0),
      .rf_dout1(rf_dout1), .rd_dout0(rd_dout0), .rd_dout1(rd_dout1),
      .busy(busy), .commit_cnt(commit_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Model: pointer, a one-entry pending-write scoreboard, commit count.
   int            m_ptr = 0;
   bit            m_sv  = 0;
   logic [AW-1:0] m_sa  = '0;
   logic [W-1:0]  m_sd  = '0;
   logic [31:0]   m_cnt = '0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int exp_grant();
      if (!rst || wb_stall) return -1;
      for (int k = 0; k < N; k++)
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
      req_valid[i]         = 1'b1;
      req_addr[i*AW +: AW] = a;
      req_data[i*W +: W]   = d;
   endtask

   // Check the current cycle, advance the model across the edge, retire the granted request.
   task automatic step();
      int           g;
      logic [N-1:0] er;
      bit           ewe;
      logic [W-1:0] eb0, eb1;
      #1;
      g   = exp_grant();
      er  = (g >= 0) ? (N'(1) << g) : '0;
      ewe = rst && m_sv && !wb_stall;
      chk("req_ready", req_ready, er);
      chk("we0", we0, ewe);
      chk("busy", busy, rst && m_sv);
      if (ewe) begin
         chk("wr_addr0", wr_addr0, m_sa);
         chk("wr_din0", wr_din0, m_sd);
      end
      if (!rst) begin
         chk("rst_wr_addr0", wr_addr0, 0);
         chk("rst_wr_din0", wr_din0, 0);
      end else begin
         chk("commit_cnt", commit_cnt, m_cnt);
`ifdef WB_BYPASS_EN
         eb0 = (m_sv && m_sa == rd_addr0) ? m_sd : rf_dout0;
         eb1 = (m_sv && m_sa == rd_addr1) ? m_sd : rf_dout1;
`else
         eb0 = rf_dout0;
         eb1 = rf_dout1;
`endif
         chk("rd_dout0", rd_dout0, eb0);
         chk("rd_dout1", rd_dout1, eb1);
      end
      @(posedge clk);
      if (!rst) begin
         m_ptr = 0; m_sv = 0; m_sa = '0; m_sd = '0; m_cnt = '0;
      end else begin
         if (ewe) m_cnt = m_cnt + 32'd1;
         if (!wb_stall) begin
            m_sv = 0;
            if (g >= 0) begin
               m_ptr = (g + 1) % N;
               if (req_addr[g*AW +: AW] != 0) begin
                  m_sv = 1;
                  m_sa = req_addr[g*AW +: AW];
                  m_sd = req_data[g*W +: W];
               end
            end
         end
      end
      @(negedge clk);
      if (g >= 0) req_valid[g] = 1'b0;
   endtask

   initial begin
      rst = 1'b0; wb_stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
      rd_addr0 = '0; rd_addr1 = '0; rf_dout0 = '0; rf_dout1 = '0;
      @(negedge clk);
      step(); step();
      rst = 1'b1;
      step();
      #1;
      chk("reset_cnt", commit_cnt, 0);
      chk("reset_busy", busy, 0);

      // Round robin with all three requesters continuously valid.
      for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), W'(32'h100 + i));
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_grant", req_ready, N'(1) << (k % 3));
         chk("rr_we0", we0, k >= 1);
         if (k == 4) chk("rr_cnt3", commit_cnt, 3);
         step();
         set_req(k % 3, AW'((k % 3) + 1), W'(32'h100 + (k % 3)));
      end
      req_valid = '0;
      step(); step();

      // x0 write accepted but dropped.
      set_req(0, '0, 32'hDEADBEEF);
      #1;
      chk("x0_ready", req_ready, 3'b001);
      step();
      #1;
      chk("x0_we0", we0, 0);
      step();
      #1;
      chk("x0_cnt", commit_cnt, 6);

      // Stall holds the staged write.
      set_req(0, 5'd5, 32'h1234);
      step();
      wb_stall = 1'b1;
      set_req(1, '0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_we0", we0, 0);
         chk("stall_ready", req_ready, 0);
         chk("stall_busy", busy, 1);
         step();
      end
      wb_stall = 1'b0;
      #1;
      chk("rel_we0", we0, 1);
      chk("rel_addr", wr_addr0, 5);
      chk("rel_data", wr_din0, 32'h1234);
      step();
      #1;
      chk("rel_once", we0, 0);
      step();

      // Same destination: later grant commits last.
      set_req(0, 5'd9, 32'hAAA1);
      set_req(1, 5'd9, 32'hBBB2);
      step(); step();
      #1;
      chk("order_we0", we0, 1);
      chk("order_addr", wr_addr0, 9);
      chk("order_data", wr_din0, 32'hBBB2);
      step();

      // Bypass of a stalled staged write.
      set_req(0, 5'd7, 32'hA5A5A5A5);
      step();
      wb_stall = 1'b1;
      rd_addr0 = 5'd7; rf_dout0 = '0; rd_addr1 = '0; rf_dout1 = 32'h13579BDF;
      #1;
`ifdef WB_BYPASS_EN
      chk("byp_rd0", rd_dout0, 32'hA5A5A5A5);
`else
      chk("byp_rd0", rd_dout0, 0);
`endif
      chk("byp_rd1", rd_dout1, 32'h13579BDF);
      step();
      wb_stall = 1'b0;
      step();

      // Reset while the stage holds a write: it must never commit.
      set_req(2, 5'd4, 32'h77);
      step();
      rst = 1'b0;
      #1;
      chk("midrst_we0", we0, 0);
      step();
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_cnt", commit_cnt, 0);
      step();

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(1, 0) == 1)
               set_req(i, ($urandom_range(7, 0) == 0) ? AW'(0) : AW'($urandom_range(31, 1)), W'($urandom));
         wb_stall = ($urandom_range(4, 0) == 0);
         rst      = ($urandom_range(99, 0) != 0);
         rd_addr0 = AW'($urandom_range(31, 0));
         rd_addr1 = AW'($urandom_range(31, 0));
         rf_dout0 = W'($urandom);
         rf_dout1 = W'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
